// File: rtl/pll_reset_ctrl.sv
// PLL power-up and lock-supervision sequencer in the refclk domain: pulses the PLL reset,
// qualifies lock stability, retries on timeout and latches a fault after repeated failures.
module pll_reset_ctrl #(
    parameter int unsigned RST_HOLD_CYCLES    = 16,
    parameter int unsigned LOCK_TIMEOUT       = 50000,
    parameter int unsigned LOCK_STABLE_CYCLES = 256,
    parameter int unsigned MAX_RETRIES        = 3
) (
    input  logic       refclk,
    input  logic       rst,
    input  logic       pll_locked,
    input  logic       restart,
    output logic       pll_rst,
    output logic       sys_rst,
    output logic       ready,
    output logic       fault,
    output logic [7:0] lock_loss_cnt,
    output logic [2:0] state_dbg
);

    // Widths floored at 1 so the minimum parameter values still give legal vectors.
    localparam int unsigned HoldW  = (RST_HOLD_CYCLES > 1) ? $clog2(RST_HOLD_CYCLES) : 1;
    localparam int unsigned TmoW   = (LOCK_TIMEOUT > 1) ? $clog2(LOCK_TIMEOUT) : 1;
    localparam int unsigned StabW  = (LOCK_STABLE_CYCLES > 1) ? $clog2(LOCK_STABLE_CYCLES) : 1;
    localparam int unsigned RetryW = $clog2(MAX_RETRIES + 1);

    localparam logic [HoldW-1:0]  HoldLast = HoldW'(RST_HOLD_CYCLES - 1);
    localparam logic [TmoW-1:0]   TmoLast  = TmoW'(LOCK_TIMEOUT - 1);
    localparam logic [StabW-1:0]  StabLast = StabW'(LOCK_STABLE_CYCLES - 1);
    localparam logic [RetryW-1:0] RetryMax = RetryW'(MAX_RETRIES);

    typedef enum logic [2:0] {
        StResetPll  = 3'd0,
        StWaitLock  = 3'd1,
        StStabilize = 3'd2,
        StRun       = 3'd3,
        StFault     = 3'd4
    } state_e;

    state_e              state_q, state_d;
    logic [1:0]          sync_q;
    logic                locked_s;
    logic [HoldW-1:0]    hold_q, hold_d;
    logic [TmoW-1:0]     tmo_q, tmo_d;
    logic [StabW-1:0]    stab_q, stab_d;
    logic [RetryW-1:0]   retry_q, retry_d, retry_inc;
    logic [7:0]          loss_q, loss_d;

    always_ff @(posedge refclk) begin
        if (rst) begin
            sync_q <= 2'b00;
        end else begin
            sync_q <= {sync_q[0], pll_locked};
        end
    end

    assign locked_s  = sync_q[1];
    assign retry_inc = retry_q + RetryW'(1);

    always_ff @(posedge refclk) begin
        if (rst) begin
            state_q <= StResetPll;
            hold_q  <= '0;
            tmo_q   <= '0;
            stab_q  <= '0;
            retry_q <= '0;
            loss_q  <= '0;
        end else begin
            state_q <= state_d;
            hold_q  <= hold_d;
            tmo_q   <= tmo_d;
            stab_q  <= stab_d;
            retry_q <= retry_d;
            loss_q  <= loss_d;
        end
    end

    always_comb begin
        state_d = state_q;
        hold_d  = hold_q;
        tmo_d   = tmo_q;
        stab_d  = stab_q;
        retry_d = retry_q;
        loss_d  = loss_q;
        case (state_q)
            StResetPll: begin
                if (hold_q == HoldLast) begin
                    state_d = StWaitLock;
                    hold_d  = '0;
                    tmo_d   = '0;
                end else begin
                    hold_d = hold_q + HoldW'(1);
                end
            end
            StWaitLock: begin
                // A lock seen on the timeout cycle still wins.
                if (locked_s) begin
                    state_d = StStabilize;
                    stab_d  = '0;
                end else if (tmo_q == TmoLast) begin
                    retry_d = retry_inc;
                    hold_d  = '0;
                    state_d = (retry_inc == RetryMax) ? StFault : StResetPll;
                end else begin
                    tmo_d = tmo_q + TmoW'(1);
                end
            end
            StStabilize: begin
                if (!locked_s) begin
                    state_d = StWaitLock;
                    tmo_d   = '0;
                end else if (stab_q == StabLast) begin
                    state_d = StRun;
                    retry_d = '0;
                end else begin
                    stab_d = stab_q + StabW'(1);
                end
            end
            StRun: begin
                if (!locked_s) begin
                    state_d = StResetPll;
                    hold_d  = '0;
                    if (loss_q != 8'hFF) begin
                        loss_d = loss_q + 8'd1;
                    end
                end
            end
            StFault: begin
                if (restart) begin
                    state_d = StResetPll;
                    hold_d  = '0;
                    retry_d = '0;
                end
            end
            default: begin
                state_d = StResetPll;
                hold_d  = '0;
            end
        endcase
    end

    always_comb begin
        pll_rst = (state_q == StResetPll) || (state_q == StFault);
        sys_rst = (state_q != StRun);
        ready   = (state_q == StRun);
        fault   = (state_q == StFault);
    end

    assign lock_loss_cnt = loss_q;
    assign state_dbg     = state_q;

endmodule
